// File: rtl/hpi_txn_engine.sv
// HPI bus transaction sequencer: queued read/write commands become timed cs/r/w pin sequences.
// Defining HPI_TXN_STATS_EN adds saturating completed-read/write counters with a clear input.
module hpi_txn_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  // cmd_valid/cmd_ready: a command transfers on every clk_clk edge where both are high;
  // cmd_ready depends only on the registered queue count, never on cmd_valid.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              otg_hpi_cs_n,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic [ADDR_W-1:0] otg_hpi_address,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe,
  input  logic [DATA_W-1:0] otg_hpi_data_in
`ifdef HPI_TXN_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
`endif
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_ST  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_ST > HOLD_CYC) ? MAX_ST : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Command queue
  logic              fifo_write [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  // Sequencer
  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  phase_cnt;
  logic              phase_last;

  // Latched transaction and the values it will hold after the current edge
  logic              txn_write;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic              txn_write_d;
  logic [ADDR_W-1:0] txn_addr_d;
  logic [DATA_W-1:0] txn_wdata_d;

  // Next pin values
  logic              cs_n_d;
  logic              r_n_d;
  logic              w_n_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] data_out_d;
  logic              data_oe_d;
  logic              capture;

  assign cmd_ready = (count != COUNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (count != '0) || (state != IDLE);

  always_ff @(posedge clk_clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    phase_last = 1'b0;
    unique case (state)
      SETUP:   phase_last = (phase_cnt == CNT_W'(SETUP_CYC - 1));
      STROBE:  phase_last = (phase_cnt == CNT_W'(STROBE_CYC - 1));
      HOLD:    phase_last = (phase_cnt == CNT_W'(HOLD_CYC - 1));
      default: phase_last = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
    end else begin
      state <= state_d;
      if ((state_d != state) || (state == IDLE))
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (count != '0) state_d = SETUP;
      SETUP:   if (phase_last)  state_d = STROBE;
      STROBE:  if (phase_last)  state_d = HOLD;
      HOLD:    if (phase_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      txn_write <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
    end else if (pop) begin
      txn_write <= fifo_write[rd_ptr];
      txn_addr  <= fifo_addr[rd_ptr];
      txn_wdata <= fifo_wdata[rd_ptr];
    end
  end

  assign txn_write_d = pop ? fifo_write[rd_ptr] : txn_write;
  assign txn_addr_d  = pop ? fifo_addr[rd_ptr]  : txn_addr;
  assign txn_wdata_d = pop ? fifo_wdata[rd_ptr] : txn_wdata;

  // FSM: outputs. Pins are computed from the next state so that the registered
  // pins line up exactly with the state they belong to.
  always_comb begin
    cs_n_d     = 1'b1;
    r_n_d      = 1'b1;
    w_n_d      = 1'b1;
    data_oe_d  = 1'b0;
    address_d  = otg_hpi_address;
    data_out_d = otg_hpi_data_out;
    if (state_d != IDLE) begin
      cs_n_d    = 1'b0;
      address_d = txn_addr_d;
      if (txn_write_d) begin
        data_oe_d  = 1'b1;
        data_out_d = txn_wdata_d;
      end
    end
    if (state_d == STROBE) begin
      r_n_d = txn_write_d;
      w_n_d = !txn_write_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      otg_hpi_cs_n     <= 1'b1;
      otg_hpi_r_n      <= 1'b1;
      otg_hpi_w_n      <= 1'b1;
      otg_hpi_address  <= '0;
      otg_hpi_data_out <= '0;
      otg_hpi_data_oe  <= 1'b0;
    end else begin
      otg_hpi_cs_n     <= cs_n_d;
      otg_hpi_r_n      <= r_n_d;
      otg_hpi_w_n      <= w_n_d;
      otg_hpi_address  <= address_d;
      otg_hpi_data_out <= data_out_d;
      otg_hpi_data_oe  <= data_oe_d;
    end
  end

  // Pad data is sampled on the edge that ends the final strobe cycle.
  assign capture = (state == STROBE) && phase_last && !txn_write;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= capture;
      if (capture) rsp_rdata <= otg_hpi_data_in;
    end
  end

`ifdef HPI_TXN_STATS_EN
  logic txn_done;
  assign txn_done = (state == HOLD) && phase_last;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (stat_clr) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (txn_done) begin
      if (txn_write && (stat_wr_cnt != 16'hFFFF)) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (!txn_write && (stat_rd_cnt != 16'hFFFF)) stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hpi_txn_engine.sv
// Bench for hpi_txn_engine: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and a fast 32-bit build.
`timescale 1ns/1ps
module tb_hpi_txn_engine;
  localparam int DW = 16, AW = 2, DEPTH = 4, S = 2, T = 3, H = 1;
  localparam int LEN = S + T + H;
  localparam int DW1 = 32;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Main DUT signals
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, data_in = '0;
  logic          stat_clr = 1'b0;
  logic          cmd_ready, rsp_valid, busy, cs_n, r_n, w_n, data_oe;
  logic [DW-1:0] rsp_rdata, data_out;
  logic [AW-1:0] address;
  logic [15:0]   stat_rd, stat_wr;

  hpi_txn_engine #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH),
                   .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n), .otg_hpi_w_n(w_n),
    .otg_hpi_address(address), .otg_hpi_data_out(data_out),
    .otg_hpi_data_oe(data_oe), .otg_hpi_data_in(data_in)
`ifdef HPI_TXN_STATS_EN
    , .stat_clr(stat_clr), .stat_rd_cnt(stat_rd), .stat_wr_cnt(stat_wr)
`endif
  );

  // Fast-timing 32-bit DUT
  logic           c1_rst_n = 1'b0, c1_valid = 1'b0, c1_write = 1'b0, c1_stat_clr = 1'b0;
  logic [AW-1:0]  c1_addr = '0;
  logic [DW1-1:0] c1_wdata = '0, c1_data_in = '0;
  logic           c1_ready, c1_rsp_valid, c1_busy, c1_cs_n, c1_r_n, c1_w_n, c1_oe;
  logic [DW1-1:0] c1_rdata, c1_data_out;
  logic [AW-1:0]  c1_address;
  logic [15:0]    c1_stat_rd, c1_stat_wr;

  hpi_txn_engine #(.DATA_W(DW1), .ADDR_W(AW), .FIFO_DEPTH(DEPTH),
                   .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut32 (
    .clk_clk(clk), .reset_reset_n(c1_rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_write(c1_write),
    .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
    .rsp_valid(c1_rsp_valid), .rsp_rdata(c1_rdata), .busy(c1_busy),
    .otg_hpi_cs_n(c1_cs_n), .otg_hpi_r_n(c1_r_n), .otg_hpi_w_n(c1_w_n),
    .otg_hpi_address(c1_address), .otg_hpi_data_out(c1_data_out),
    .otg_hpi_data_oe(c1_oe), .otg_hpi_data_in(c1_data_in)
`ifdef HPI_TXN_STATS_EN
    , .stat_clr(c1_stat_clr), .stat_rd_cnt(c1_stat_rd), .stat_wr_cnt(c1_stat_wr)
`endif
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue plus the position of the active transaction
  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
  cmd_t          mq[$];
  cmd_t          m_cur, m_new;
  bit            m_valid = 0, m_active = 0, m_ready_pre;
  int            m_k = 0, m_size_pre, m_rd = 0, m_wr = 0;
  logic [DW-1:0] m_rdata = '0, m_wdata = '0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_k = 0; m_rdata = '0; m_wdata = '0; m_addr = '0;
      m_rd = 0; m_wr = 0; m_valid = 1;
    end else if (m_valid) begin
      m_ready_pre = (mq.size() != DEPTH);
      m_size_pre  = mq.size();
      if (m_active && !m_cur.w && m_k == S + T - 1) m_rdata = data_in;
      if (stat_clr) begin
        m_rd = 0; m_wr = 0;
      end else if (m_active && m_k == LEN - 1) begin
        if (m_cur.w) m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
        else         m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
      end
      if (m_active) begin
        m_k++;
        if (m_k == LEN) m_active = 0;
      end else if (m_size_pre != 0) begin
        m_cur = mq.pop_front();
        m_active = 1; m_k = 0; m_addr = m_cur.a;
        if (m_cur.w) m_wdata = m_cur.d;
      end
      if (cmd_valid && m_ready_pre) begin
        m_new.w = cmd_write; m_new.a = cmd_addr; m_new.d = cmd_wdata;
        mq.push_back(m_new);
      end
    end
  end

  // Scoreboard compare, every cycle, 2ns after the edge
  bit e_stb;
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      e_stb = m_active && (m_k >= S) && (m_k < S + T);
      chk("ctrl{cs,r,w,oe,rsp,rdy,busy}", {cs_n, r_n, w_n, data_oe, rsp_valid, cmd_ready, busy},
          {!m_active, !(e_stb && !m_cur.w), !(e_stb && m_cur.w), m_active && m_cur.w,
           m_active && !m_cur.w && (m_k == S + T), mq.size() != DEPTH, (mq.size() != 0) || m_active});
      chk("address", address, m_addr);
      chk("data_out", data_out, m_wdata);
      chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef HPI_TXN_STATS_EN
      chk("stat_rd_cnt", stat_rd, m_rd);
      chk("stat_wr_cnt", stat_wr, m_wr);
`endif
    end
  end

  // Driver tasks (called at negedge)
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  // Records pin activity relative to the first cycle cs_n is low
  task automatic trace(input logic [DW-1:0] dexp, output int cs_low, output int stb_low,
                       output int stb_first, output int rsp_cnt, output int rsp_idx,
                       output int oe_cnt, output int dout_ok);
    int i = -1;
    cs_low = 0; stb_low = 0; stb_first = -1; rsp_cnt = 0; rsp_idx = -1; oe_cnt = 0; dout_ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (!cs_n && i < 0) i = 0;
      if (i >= 0) begin
        if (!cs_n) cs_low++;
        if (!r_n || !w_n) begin
          if (stb_first < 0) stb_first = i;
          stb_low++;
        end
        if (rsp_valid) begin rsp_cnt++; rsp_idx = i; end
        if (data_oe) oe_cnt++;
        if (!cs_n && data_out == dexp) dout_ok++;
        i++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w8, cl, sl, sf, rc, ri, oc, dk, cs_seen;
  int fall0, fall1, wl, rl, rsp1, dout1_ok, addr_rd_ok;
  logic prev_cs;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cs_n", cs_n, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdata", rsp_rdata, '0);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_addr", address, '0);

    // Single write
    send(1'b1, 2'd2, 16'hBEEF, w8);
    trace(16'hBEEF, cl, sl, sf, rc, ri, oc, dk);
    chk("wr_cs_low", cl, 6);
    chk("wr_w_low", sl, 3);
    chk("wr_w_first", sf, 2);
    chk("wr_rsp_cnt", rc, 0);
    chk("wr_oe_cnt", oc, 6);
    chk("wr_dout_ok", dk, 6);
    chk("wr_addr_held", address, 2'd2);

    // Single read with pad driving 16'h1234
    data_in = 16'h1234;
    send(1'b0, 2'd1, 16'h0, w8);
    trace(16'hBEEF, cl, sl, sf, rc, ri, oc, dk);
    chk("rd_cs_low", cl, 6);
    chk("rd_r_low", sl, 3);
    chk("rd_r_first", sf, 2);
    chk("rd_rsp_cnt", rc, 1);
    chk("rd_rsp_idx", ri, 5);
    chk("rd_oe_cnt", oc, 0);
    chk("rd_rdata", rsp_rdata, 16'h1234);
    data_in = 16'h0;
    repeat (3) @(negedge clk);
    chk("rd_rdata_hold", rsp_rdata, 16'h1234);

    // Fill the queue behind a running read
    send(1'b0, 2'd3, 16'h0, w8);
    for (int i = 0; i < 4; i++) send(1'b1, AW'(i), DW'(16'h1000 + i), w8);
    chk("full_ready", cmd_ready, 1'b0);
    send(1'b1, 2'd0, 16'h2004, w8);
    chk("full_wait", w8, 4);
    wait_idle(200);

    // Randomized traffic
    begin
      bit ready_seen = 0;
      for (int c = 0; c < 2000; c++) begin
        if (!cmd_valid || ready_seen) begin
          cmd_valid = ($urandom_range(0, 3) != 0) && ((c / 200) % 2 == 0 || $urandom_range(0, 5) == 0);
          cmd_write = $urandom_range(0, 1);
          cmd_addr  = AW'($urandom);
          cmd_wdata = DW'($urandom);
        end
        data_in  = DW'($urandom);
        stat_clr = ($urandom_range(0, 63) == 0);
        ready_seen = cmd_ready;
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      stat_clr  = 1'b0;
      wait_idle(300);
    end

    // Reset in the middle of a read strobe with two commands queued
    send(1'b0, 2'd1, 16'h0, w8);
    send(1'b1, 2'd2, 16'h5555, w8);
    send(1'b1, 2'd3, 16'hAAAA, w8);
    w8 = 0;
    while (r_n && w8 < 30) begin @(negedge clk); w8++; end
    chk("mid_strobe_reached", r_n, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_r_n", r_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_oe", data_oe, 1'b0);
    rst_n = 1'b1;
    cs_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cs_n) cs_seen++;
    end
    chk("no_stale_cmd", cs_seen, 0);

`ifdef HPI_TXN_STATS_EN
    // Counters: 3 reads + 2 writes, then clear during a completing write
    for (int i = 0; i < 3; i++) send(1'b0, AW'(i), 16'h0, w8);
    for (int i = 0; i < 2; i++) send(1'b1, AW'(i), 16'h0F0F, w8);
    wait_idle(200);
    chk("stat_rd3", stat_rd, 16'd3);
    chk("stat_wr2", stat_wr, 16'd2);
    send(1'b1, 2'd1, 16'h7777, w8);
    w8 = 0;
    while (w_n && w8 < 30) begin @(negedge clk); w8++; end
    stat_clr = 1'b1;
    wait_idle(50);
    stat_clr = 1'b0;
    chk("stat_clr_rd", stat_rd, 16'd0);
    chk("stat_clr_wr", stat_wr, 16'd0);
`endif

    // 32-bit build with 1/1/1 timing: write then read
    repeat (2) @(negedge clk);
    c1_rst_n = 1'b1;
    c1_data_in = 32'hA5A5_5A5A;
    c1_valid = 1'b1; c1_write = 1'b1; c1_addr = 2'd3; c1_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    c1_write = 1'b0; c1_addr = 2'd2; c1_wdata = 32'h0;
    @(negedge clk);
    c1_valid = 1'b0;
    fall0 = -1; fall1 = -1; wl = 0; rl = 0; rsp1 = 0; dout1_ok = 0; addr_rd_ok = 0;
    prev_cs = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (prev_cs && !c1_cs_n) begin
        if (fall0 < 0) fall0 = i; else if (fall1 < 0) fall1 = i;
      end
      prev_cs = c1_cs_n;
      if (!c1_w_n) begin wl++; if (c1_data_out == 32'hA5A5_5A5A && c1_oe) dout1_ok++; end
      if (!c1_r_n) begin rl++; if (c1_address == 2'd2) addr_rd_ok++; end
      if (c1_rsp_valid) rsp1++;
      @(negedge clk);
    end
    chk("w32_first_fall", fall0, 0);
    chk("w32_period", fall1 - fall0, 4);
    chk("w32_w_low", wl, 1);
    chk("w32_wdata", dout1_ok, 1);
    chk("w32_r_low", rl, 1);
    chk("w32_rd_addr", addr_rd_ok, 1);
    chk("w32_rsp_cnt", rsp1, 1);
    chk("w32_rdata", c1_rdata, 32'hA5A5_5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
